ula_serial: RTL and testbench
=============================

ULA_SERIAL -- requirements
Module: ula_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, bits processed per compute cycle; WIDTH SHALL be an integer multiple of DIGIT, and NDIG = WIDTH/DIGIT.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- abort  in  1  synchronous cancel of an operation in progress.
- ULAcontrole  in  3  opcode, sampled on accept.
- a, b  in  WIDTH  operands, sampled on accept.
- ready  out  1  idle, can accept.
- done  out  1  one-cycle completion pulse.
- ULAsaida  out  WIDTH  result register.
- cout  out  1  final carry.
- overflow  out  1  signed overflow.
- zero  out  1  ULAsaida == 0.

Function
REQ-004 Opcodes SHALL be: 000 AND, 001 OR, 010 ADD, 011 NOR, 100 constant 0, 101 XOR, 110 SUB (a + ~b + 1), 111 SLT (signed a<b -> 1, else 0).
REQ-005 The FSM SHALL have states IDLE, RUN and DONE, and SHALL be in IDLE after reset.
REQ-006 In IDLE, ready SHALL be 1; start=1 with abort=0 SHALL latch a, b and ULAcontrole, clear the digit counter, preload the carry register (1 for SUB/SLT, 0 otherwise), and enter RUN.
REQ-007 RUN cycle k (k = 0..NDIG-1) SHALL compute operand bits [k*DIGIT +: DIGIT] using the registered carry, write the result digit into ULAsaida (except SLT), update the carry register, and increment the counter.
REQ-008 On RUN cycle k = NDIG-1, the FSM SHALL enter DONE.
REQ-009 Latency SHALL be exactly NDIG+1 cycles from the accept edge to the edge that asserts done; DIGIT = WIDTH SHALL give one RUN cycle.
REQ-010 In DONE, done SHALL be 1 and ready SHALL be 0 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-011 For ADD/SUB, on the final digit: cout SHALL be the carry out of bit WIDTH-1, and overflow SHALL be the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-012 For SLT, ULAsaida SHALL be set on the final digit to {WIDTH-1 zeros, sum[WIDTH-1] XOR overflow_internal}, and cout and overflow SHALL be 0.
REQ-013 For the logic ops (000, 001, 011, 100, 101), cout and overflow SHALL be 0.
REQ-014 ULAsaida, cout and overflow SHALL change only during RUN, SHALL hold their values in DONE and IDLE until the next accepted start, and zero SHALL be combinational from ULAsaida.
REQ-015 start SHALL be ignored in RUN and DONE; there SHALL be no queuing.
REQ-016 When start is asserted in the cycle done is asserted, it SHALL be ignored; the request SHALL be accepted when presented in the following IDLE cycle.
REQ-017 abort=1 in RUN SHALL return the FSM to IDLE next edge without asserting done, leaving ULAsaida partially updated; ULAsaida, cout and overflow SHALL be undefined for use until the next completed operation.
REQ-018 abort=1 in IDLE together with start=1 SHALL win: the request SHALL not be accepted.
REQ-019 Changes on the a, b and ULAcontrole inputs after accept SHALL not affect the operation in progress.

Reset
REQ-020 reset=1 SHALL immediately force the FSM to IDLE, clear the counter and carry register, and set ULAsaida=0, cout=0, overflow=0, done=0, ready=1 and zero=1, including when reset is asserted mid-operation.
REQ-021 After reset deasserts, the first start SHALL be accepted on the next clock edge.

Verification
REQ-022 WIDTH=32, DIGIT=1, ADD a=0x7FFFFFFF, b=1 -> done exactly 33 cycles after accept; ULAsaida=0x80000000, overflow=1, cout=0, zero=0.
REQ-023 WIDTH=32, DIGIT=8, SUB a=5, b=5 -> done exactly 5 cycles after accept; ULAsaida=0, zero=1, cout=1, overflow=0.
REQ-024 WIDTH=32, DIGIT=8, SLT a=0x80000000, b=1 -> ULAsaida=1; SLT a=1, b=0xFFFFFFFF -> ULAsaida=0.
REQ-025 WIDTH=32, DIGIT=4, NOR a=0, b=0x0000FFFF -> ULAsaida=0xFFFF0000; start pulsed during RUN -> ignored; exactly one done pulse; ready stays 0 until the cycle after done.
REQ-026 WIDTH=32, DIGIT=1, ADD started, reset asserted at RUN cycle 10 -> outputs immediately take the reset values of REQ-020; next ADD 2+3 -> ULAsaida=5.
REQ-027 WIDTH=32, DIGIT=1, abort at RUN cycle 4 -> no done, ready=1 next cycle; start with abort=1 in IDLE -> not accepted.

Source files
------------

// File: rtl/ula_serial_if.sv
// Handshake and operand/result bundle for the digit-serial ALU.
// Signal names match the ALU's external pin names; clk and reset stay outside.
interface ula_serial_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             abort;
  logic [2:0]       ULAcontrole;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] ULAsaida;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, abort, ULAcontrole, a, b,
    input  ready, done, ULAsaida, cout, overflow, zero
  );

  modport slave (
    input  start, abort, ULAcontrole, a, b,
    output ready, done, ULAsaida, cout, overflow, zero
  );
endinterface

// File: rtl/ula_serial.sv
// Digit-serial ALU: processes DIGIT bits per cycle with a registered ripple carry,
// taking WIDTH/DIGIT RUN cycles followed by a one-cycle DONE pulse.
module ula_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  ula_serial_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] a_dig_s, b_dig_s, b_eff_s, dig_res_s;
  logic [DIGIT:0]   sum_s;
  logic             last_s, cin_msb_s, ovf_s, is_sub_s;

  // Current digit slice; SUB and SLT add the inverted b with the carry preloaded to 1.
  always_comb begin
    a_dig_s   = a_q[cnt_q*DIGIT +: DIGIT];
    b_dig_s   = b_q[cnt_q*DIGIT +: DIGIT];
    is_sub_s  = (op_q == 3'b110) || (op_q == 3'b111);
    b_eff_s   = is_sub_s ? ~b_dig_s : b_dig_s;
    sum_s     = {1'b0, a_dig_s} + {1'b0, b_eff_s} + {{DIGIT{1'b0}}, carry_q};
    cin_msb_s = sum_s[DIGIT-1] ^ a_dig_s[DIGIT-1] ^ b_eff_s[DIGIT-1];
    ovf_s     = cin_msb_s ^ sum_s[DIGIT];
    last_s    = (cnt_q == CW'(NDIG - 1));
    case (op_q)
      3'b000:  dig_res_s = a_dig_s & b_dig_s;
      3'b001:  dig_res_s = a_dig_s | b_dig_s;
      3'b010:  dig_res_s = sum_s[DIGIT-1:0];
      3'b011:  dig_res_s = ~(a_dig_s | b_dig_s);
      3'b101:  dig_res_s = a_dig_s ^ b_dig_s;
      3'b110:  dig_res_s = sum_s[DIGIT-1:0];
      default: dig_res_s = {DIGIT{1'b0}};
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          op_d    = bus.ULAcontrole;
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = {CW{1'b0}};
          carry_d = (bus.ULAcontrole == 3'b110) || (bus.ULAcontrole == 3'b111);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          carry_d = sum_s[DIGIT];
          cnt_d   = last_s ? {CW{1'b0}} : cnt_q + 1'b1;
          if (op_q != 3'b111) begin
            res_d[cnt_q*DIGIT +: DIGIT] = dig_res_s;
          end else begin
            res_d = res_q;
          end
          if (last_s) begin
            state_d = DONE;
            if (op_q == 3'b111) begin
              res_d  = {{(WIDTH-1){1'b0}}, sum_s[DIGIT-1] ^ ovf_s};
              cout_d = 1'b0;
              ovf_d  = 1'b0;
            end else if ((op_q == 3'b010) || (op_q == 3'b110)) begin
              cout_d = sum_s[DIGIT];
              ovf_d  = ovf_s;
            end else begin
              cout_d = 1'b0;
              ovf_d  = 1'b0;
            end
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 3'b000;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      res_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.ULAsaida = res_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = (res_q == {WIDTH{1'b0}});
endmodule

// File: tb/tb_ula_serial.sv
// Bench for ula_serial: three instances (DIGIT 1, 8, 4) share stimulus; a scoreboard
// queue holds expected results and a negedge monitor compares them on each done pulse.
module tb_ula_serial;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_s = 1'b0, abort_s = 1'b0;
  logic [2:0]  op_s = 3'b000;
  logic [31:0] a_s = 32'h0, b_s = 32'h0;
  logic [1:0]  sel = 2'd0;

  always #5 clk = ~clk;

  ula_serial_if #(.WIDTH(32)) if1 ();
  ula_serial_if #(.WIDTH(32)) if8 ();
  ula_serial_if #(.WIDTH(32)) if4 ();

  assign if1.start = start_s && (sel == 2'd0);
  assign if8.start = start_s && (sel == 2'd1);
  assign if4.start = start_s && (sel == 2'd2);
  assign if1.abort = abort_s;  assign if8.abort = abort_s;  assign if4.abort = abort_s;
  assign if1.ULAcontrole = op_s; assign if8.ULAcontrole = op_s; assign if4.ULAcontrole = op_s;
  assign if1.a = a_s;  assign if8.a = a_s;  assign if4.a = a_s;
  assign if1.b = b_s;  assign if8.b = b_s;  assign if4.b = b_s;

  ula_serial #(.WIDTH(32), .DIGIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  ula_serial #(.WIDTH(32), .DIGIT(8)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  ula_serial #(.WIDTH(32), .DIGIT(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  // {ready, done, cout, overflow, zero, ULAsaida} of the selected instance
  logic [36:0] o1, o8, o4, out_m;
  assign o1 = {if1.ready, if1.done, if1.cout, if1.overflow, if1.zero, if1.ULAsaida};
  assign o8 = {if8.ready, if8.done, if8.cout, if8.overflow, if8.zero, if8.ULAsaida};
  assign o4 = {if4.ready, if4.done, if4.cout, if4.overflow, if4.zero, if4.ULAsaida};
  always_comb begin
    case (sel)
      2'd1:    out_m = o8;
      2'd2:    out_m = o4;
      default: out_m = o1;
    endcase
  end
  wire        ready_m = out_m[36];
  wire        done_m  = out_m[35];
  wire        cout_m  = out_m[34];
  wire        ovf_m   = out_m[33];
  wire        zero_m  = out_m[32];
  wire [31:0] res_m   = out_m[31:0];

  localparam logic [36:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};

  typedef struct { logic [31:0] res; logic c; logic v; int lat; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, cyc = 0, acc_cyc = 0;

  function automatic int ndig(input logic [1:0] s);
    case (s)
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 32;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int nd);
    exp_t e;
    logic [32:0] s;
    e.res = 32'h0; e.c = 1'b0; e.v = 1'b0; e.lat = nd + 1;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0]; e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b011: e.res = ~(a | b);
      3'b101: e.res = a ^ b;
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.res = s[31:0]; e.c = s[32];
        e.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'b111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = 32'h0;
    endcase
    return e;
  endfunction

  // Scoreboard monitor: record accept cycle, compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && start_s && !abort_s && ready_m) acc_cyc = cyc;
    if (!reset && done_m) begin
      if (q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_done sel=%0d res=%h", sel, res_m);
      end else begin
        e = q.pop_front();
        checks++;
        if (res_m !== e.res) begin errors++; $display("FAIL result sel=%0d got=%h exp=%h", sel, res_m, e.res); end
        checks++;
        if (cout_m !== e.c) begin errors++; $display("FAIL cout sel=%0d got=%b exp=%b", sel, cout_m, e.c); end
        checks++;
        if (ovf_m !== e.v) begin errors++; $display("FAIL overflow sel=%0d got=%b exp=%b", sel, ovf_m, e.v); end
        checks++;
        if (zero_m !== (e.res == 32'h0)) begin errors++; $display("FAIL zero sel=%0d got=%b exp=%b", sel, zero_m, (e.res == 32'h0)); end
        checks++;
        if ((cyc - acc_cyc) != e.lat) begin errors++; $display("FAIL latency sel=%0d got=%0d exp=%0d", sel, cyc - acc_cyc, e.lat); end
      end
    end
  end

  task automatic issue(input logic [1:0] s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
    int n = 0;
    sel = s;
    @(posedge clk); #1;
    while (ready_m !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin errors++; checks++; $display("FAIL ready_timeout sel=%0d got=%b exp=1", s, ready_m); end
    start_s = 1'b1; op_s = op; a_s = a; b_s = b;
    if (push) q.push_back(model(op, a, b, ndig(s)));
    @(posedge clk); #1;
    start_s = 1'b0; a_s = $urandom; b_s = $urandom; op_s = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL done_timeout sel=%0d pending=%0d exp=0", sel, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s); #1;
      checks++;
      if (out_m !== RST_VEC) begin errors++; $display("FAIL reset_state sel=%0d got=%h exp=%h", s, out_m, RST_VEC); end
    end
    reset = 1'b0;
  endtask

  task automatic test_add_overflow();
    issue(2'd0, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    wait_idle();
  endtask

  task automatic test_sub_slt();
    issue(2'd1, 3'b110, 32'd5, 32'd5, 1'b1);
    issue(2'd1, 3'b111, 32'h8000_0000, 32'h0000_0001, 1'b1);
    issue(2'd1, 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    issue(2'd1, 3'b110, 32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_idle();
  endtask

  task automatic test_start_ignored();
    int k = 0, dn = 0;
    issue(2'd2, 3'b011, 32'h0, 32'h0000_FFFF, 1'b1);
    while (k < 50) begin
      @(negedge clk); k++;
      if (done_m) begin dn++; break; end
      checks++;
      if (ready_m !== 1'b0) begin errors++; $display("FAIL ready_in_run k=%0d got=%b exp=0", k, ready_m); end
      if (k == 2) begin #1; start_s = 1'b1; a_s = 32'hFFFF_FFFF; op_s = 3'b001; end
      if (k == 4) begin #1; start_s = 1'b0; end
    end
    @(negedge clk);
    checks++;
    if (ready_m !== 1'b1) begin errors++; $display("FAIL ready_after_done got=%b exp=1", ready_m); end
    repeat (10) begin if (done_m) dn++; @(negedge clk); end
    checks++;
    if (dn != 1) begin errors++; $display("FAIL done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_start_at_done();
    int n = 0;
    issue(2'd2, 3'b010, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    while (!done_m && n < 50) begin @(negedge clk); n++; end
    #1;
    start_s = 1'b1; op_s = 3'b101; a_s = 32'hA5A5_0F0F; b_s = 32'h0FF0_FFFF;
    q.push_back(model(3'b101, 32'hA5A5_0F0F, 32'h0FF0_FFFF, ndig(2'd2)));
    @(posedge clk); @(posedge clk); #1;
    start_s = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid_run();
    issue(2'd0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) @(posedge clk);
    #2; reset = 1'b1; #1;
    checks++;
    if (out_m !== RST_VEC) begin errors++; $display("FAIL reset_mid_run got=%h exp=%h", out_m, RST_VEC); end
    @(posedge clk); #1; reset = 1'b0;
    issue(2'd0, 3'b010, 32'd2, 32'd3, 1'b1);
    wait_idle();
  endtask

  task automatic test_abort();
    issue(2'd0, 3'b010, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    repeat (4) @(posedge clk);
    #1; abort_s = 1'b1;
    @(posedge clk); #1; abort_s = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_m, done_m} !== 2'b10) begin errors++; $display("FAIL abort_ready got=%b exp=10", {ready_m, done_m}); end
    repeat (40) @(negedge clk);
    #1; start_s = 1'b1; abort_s = 1'b1; op_s = 3'b010;
    @(posedge clk); #1; start_s = 1'b0; abort_s = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_m !== 1'b1) begin errors++; $display("FAIL abort_wins got=%b exp=1", ready_m); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
      issue(2'($urandom_range(0, 2)), 3'(i % 8), a, b, 1'b1);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_start_ignored();
    test_start_at_done();
    test_reset_mid_run();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
